hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It issues the enable and flush controls that the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers consume. It detects load-use hazards, redirects on taken branches and jumps, and freezes the pipeline while data memory stalls. It also enforces a memory-wait timeout and keeps saturating stall and flush counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive freeze cycles per memory access; legal range is 1 to 255.
- CNT_W, 32: width of the performance counters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5  source register fields of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads that source.
- ex_mem_read  in  3  mem_read field of ID_EX; nonzero means the EX instruction is a load.
- ex_reg_write  in  1  reg_write field of ID_EX.
- ex_write_reg  in  6  write_reg field of ID_EX; only bits [4:0] are compared.
- ex_redirect  in  1  EX resolved a taken branch or a jump (jump field nonzero).
- mem_req  in  1  the instruction in MEM is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  insert a bubble (zeros) on the next edge.
- mem_err  out  1  sticky flag: a memory timeout occurred.
- stall_cnt  out  CNT_W  cycles lost to load-use or memory freeze.
- flush_cnt  out  CNT_W  number of redirects taken.

## Operation
- **FSM states:**
  - RUN: wait counter is 0.
  - MEM_WAIT: wait counter holds the number of freeze cycles so far.
- **Freeze condition:**
  - RUN: freeze when mem_req && !mem_ready. Next state is MEM_WAIT with wait_cnt = 1.
  - MEM_WAIT with mem_ready = 1, or with mem_req dropped: no freeze. Next state is RUN.
  - MEM_WAIT with wait_cnt == MEM_TIMEOUT and not ready: no freeze. Set mem_err to 1 and go to RUN.
  - MEM_WAIT otherwise: freeze and increment wait_cnt.
  - The longest possible freeze is MEM_TIMEOUT cycles.
- **Freeze outputs:** all four enables are 0, mem_wb_flush = 1, other flushes are 0. stall_cnt increments.
- **Redirect** (no freeze, ex_redirect = 1): all enables are 1, if_id_flush = 1, id_ex_flush = 1. flush_cnt increments.
- **Load-use** (no freeze, no redirect): the hazard is ex_mem_read != 0 && ex_reg_write && ex_write_reg[4:0] != 0 && ((id_use_rs1 && id_rs1 == ex_write_reg[4:0]) || (id_use_rs2 && id_rs2 == ex_write_reg[4:0])).
  - Outputs: pc_en = 0, if_id_en = 0, id_ex_flush = 1, id_ex_en = 1, ex_mem_en = 1.
  - stall_cnt increments.
- **Priority:** freeze, then redirect, then load-use. A redirect or load-use that coincides with a freeze is re-evaluated after release, because the pipeline inputs are held.
- **Default:** all enables are 1, all flushes are 0.
- **Counters:** both saturate at 2^CNT_W − 1. They never wrap.

## Timing
- All enable and flush outputs are combinational from the current inputs and the registered state, so they act in the same cycle. There is no added latency.
- State, wait_cnt, mem_err and both counters update on the rising edge of clk.
- While rst = 1:
  - All enables and flushes are forced to 0.
  - State is RUN, wait_cnt is 0, mem_err is 0, and both counters are 0.
  - Reset taken mid-freeze abandons the wait immediately.
- mem_err clears only on rst.
- The counter increments for a cycle become visible on the following edge.

## Structure
- pipeline_pkg holds:
  - the state typedef (RUN, MEM_WAIT);
  - the register-index width (5) and the write_reg field width (6);
  - the constant MEM_READ_NONE = 3'b000.
- One sub-module, hazard_sat_cnt: a CNT_W saturating counter with an increment input and asynchronous reset. It is instantiated twice, for stall_cnt and flush_cnt.

## Test plan
- **Load-use:** ex_mem_read = 3'b010, ex_reg_write = 1, ex_write_reg = 6'd5, id_rs1 = 5, id_use_rs1 = 1 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for one cycle; stall_cnt goes 0 to 1. Repeat with ex_write_reg = 0 -> no stall.
- **Redirect:** ex_redirect = 1 together with a load-use match -> if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt = 1, stall_cnt unchanged.
- **Memory wait:** mem_req = 1, mem_ready = 0 for 3 cycles, then ready -> enables are 0 and mem_wb_flush = 1 for exactly 3 cycles; release on the 4th cycle; stall_cnt = 3; mem_err = 0.
- **Timeout:** MEM_TIMEOUT = 4, mem_ready held 0 -> freeze for 4 cycles; 5th cycle releases; mem_err rises and stays 1.
- **Reset mid-freeze:** assert rst in freeze cycle 2 -> outputs go to 0 asynchronously; after release, state is RUN and both counters read 0.
- **Saturation:** CNT_W = 3 with 10 consecutive stall cycles -> stall_cnt holds at 7.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and field widths for the five-stage pipeline control logic.
package pipeline_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam int REG_IDX_W     = 5;
   localparam int WRITE_REG_W   = 6;
   localparam logic [2:0] MEM_READ_NONE = 3'b000;

   function automatic logic src_hit(input logic use_src,
                                    input logic [REG_IDX_W-1:0] rs,
                                    input logic [REG_IDX_W-1:0] rd);
      return use_src && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter: adds one per cycle that inc is high, holds at all-ones.
// Result is visible after the edge; async active-high reset clears it.
module hazard_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, data-memory freeze with timeout.
// Enables/flushes are combinational in the same cycle; nothing pushes back on this block.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_IDX_W-1:0]   id_rs1,
   input  logic [REG_IDX_W-1:0]   id_rs2,
   input  logic                   id_use_rs1,
   input  logic                   id_use_rs2,
   input  logic [2:0]             ex_mem_read,
   input  logic                   ex_reg_write,
   input  logic [WRITE_REG_W-1:0] ex_write_reg,
   input  logic                   ex_redirect,
   input  logic                   mem_req,
   input  logic                   mem_ready,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_ex_en,
   output logic                   ex_mem_en,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   mem_wb_flush,
   output logic                   mem_err,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);

   localparam int WAIT_W = 8;
   localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                freeze;
   logic                timeout;
   logic                load_use;
   logic                redirect;
   logic                stall_inc;
   logic [REG_IDX_W-1:0] ex_rd;
   logic                unused_write_reg_msb;

   assign ex_rd                = ex_write_reg[REG_IDX_W-1:0];
   assign unused_write_reg_msb = ex_write_reg[WRITE_REG_W-1];

   always_comb begin
      freeze  = 1'b0;
      timeout = 1'b0;
      case (state)
         RUN:      freeze = mem_req && !mem_ready;
         MEM_WAIT: begin
            if (mem_req && !mem_ready) begin
               if (wait_cnt == TIMEOUT)
                  timeout = 1'b1;
               else
                  freeze = 1'b1;
            end
         end
         default:  freeze = 1'b0;
      endcase
   end

   assign load_use = (ex_mem_read != MEM_READ_NONE) && ex_reg_write && (ex_rd != '0) &&
                     (src_hit(id_use_rs1, id_rs1, ex_rd) || src_hit(id_use_rs2, id_rs2, ex_rd));

   // Held pipeline inputs mean a redirect or load-use under freeze is simply seen again after release.
   assign redirect  = !rst && !freeze && ex_redirect;
   assign stall_inc = !rst && (freeze || (!ex_redirect && load_use));

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
      end else if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (freeze) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (freeze) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end else begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
         if (timeout)
            mem_err <= 1'b1;
      end
   end

   hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (redirect),
      .cnt (flush_cnt)
   );

endmodule
